// File: rtl/alm_config_loader_pkg.sv
// Shared definitions for the ALM_HF column configuration loader.
// Holds the loader state encoding and the per-tile chain-length constants.
package alm_config_loader_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOAD,
    ST_SHIFT,
    ST_DRAIN
  } state_e;

  localparam int unsigned CHAIN_BITS_PER_ALM = 60;
  localparam int unsigned CHAIN_BITS_PER_HF  = 10;

  // Total serial config bits for a column built from n_alm ALMs and n_hf HF tiles.
  function automatic int unsigned column_chain_len(input int unsigned n_alm,
                                                   input int unsigned n_hf);
    return n_alm * CHAIN_BITS_PER_ALM + n_hf * CHAIN_BITS_PER_HF;
  endfunction

endpackage

// File: rtl/alm_config_loader_serdes.sv
// Word-level serialiser/deserialiser for the config chain: shifts a word out
// LSB-first onto cfg_in and gathers the displaced cfg_out bits into a readback word.
module alm_cfg_serdes #(
  parameter int unsigned W  = 32,
  parameter int unsigned IW = $clog2(W)
) (
  input  logic          clk,
  input  logic          clear_async,
  input  logic          load_en,
  input  logic [W-1:0]  load_word,
  input  logic [IW-1:0] load_last_idx,
  input  logic          shift_en,
  input  logic          cfg_out,
  output logic          cfg_in,
  output logic [W-1:0]  rb_word,
  output logic          last_bit
);

  logic [W-1:0]  shift_q, shift_d;
  logic [W-1:0]  cap_q, cap_d;
  logic [IW-1:0] idx_q, idx_d;
  logic [IW-1:0] last_idx_q, last_idx_d;
  logic          bit_q, bit_d;
  logic [W-1:0]  cap_hit;

  assign last_bit = (idx_q == last_idx_q);

  for (genvar gi = 0; gi < W; gi++) begin : g_hit
    assign cap_hit[gi] = shift_en && (idx_q == IW'(gi));
  end

  always_comb begin
    shift_d    = shift_q;
    cap_d      = cap_q;
    idx_d      = idx_q;
    last_idx_d = last_idx_q;
    bit_d      = bit_q;
    if (load_en) begin
      // Bit 0 goes straight to the output flop; the rest waits in shift_q.
      shift_d    = load_word >> 1;
      bit_d      = load_word[0];
      cap_d      = '0;
      idx_d      = '0;
      last_idx_d = load_last_idx;
    end else if (shift_en) begin
      cap_d   = (cap_q & ~cap_hit) | (cap_hit & {W{cfg_out}});
      shift_d = shift_q >> 1;
      if (last_bit) begin
        bit_d = 1'b0;
      end else begin
        bit_d = shift_q[0];
        idx_d = idx_q + IW'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge clear_async) begin
    if (clear_async) begin
      shift_q    <= '0;
      cap_q      <= '0;
      idx_q      <= '0;
      last_idx_q <= '0;
      bit_q      <= 1'b0;
    end else begin
      shift_q    <= shift_d;
      cap_q      <= cap_d;
      idx_q      <= idx_d;
      last_idx_q <= last_idx_d;
      bit_q      <= bit_d;
    end
  end

  assign cfg_in  = bit_q;
  assign rb_word = cap_q;

endmodule

// File: rtl/alm_config_loader.sv
// Loads a column of ALM_HF tiles through their serial config chain and streams
// the displaced chain contents back out as readback words.
module alm_config_loader
  import alm_config_loader_pkg::*;
#(
  parameter int unsigned CHAIN_LEN = column_chain_len(1, 1),
  parameter int unsigned W         = 32
) (
  input  logic         clk,
  input  logic         clear_async,
  input  logic         start,
  output logic         busy,
  output logic         done,
  input  logic [W-1:0] in_data,
  input  logic         in_valid,
  output logic         in_ready,
  output logic [W-1:0] rb_data,
  output logic         rb_valid,
  input  logic         rb_ready,
  output logic         cfg_in,
  output logic         cfg_en,
  input  logic         cfg_out
);

  localparam int unsigned BLW = $clog2(CHAIN_LEN + 1);
  localparam int unsigned IW  = $clog2(W);

  state_e         state_q, state_d;
  logic [BLW-1:0] bits_left_q, bits_left_d;
  logic           busy_q, busy_d;
  logic           done_q, done_d;
  logic           in_ready_q, in_ready_d;
  logic           rb_valid_q, rb_valid_d;
  logic           cfg_en_q, cfg_en_d;

  logic           load_en;
  logic           last_bit;
  logic           rb_fire;
  logic [31:0]    bits_left_ext;
  logic [31:0]    n_ext;
  logic [IW-1:0]  load_last_idx;

  // The final word of a load may be shorter than W.
  assign bits_left_ext = 32'(bits_left_q);
  assign n_ext         = (bits_left_ext >= 32'(W)) ? 32'(W) : bits_left_ext;
  assign load_last_idx = IW'(n_ext - 32'd1);
  assign rb_fire       = rb_valid_q && rb_ready;

  alm_cfg_serdes #(
    .W  (W),
    .IW (IW)
  ) u_serdes (
    .clk           (clk),
    .clear_async   (clear_async),
    .load_en       (load_en),
    .load_word     (in_data),
    .load_last_idx (load_last_idx),
    .shift_en      (cfg_en_q),
    .cfg_out       (cfg_out),
    .cfg_in        (cfg_in),
    .rb_word       (rb_data),
    .last_bit      (last_bit)
  );

  always_comb begin
    state_d     = state_q;
    bits_left_d = bits_left_q;
    rb_valid_d  = rb_valid_q;
    cfg_en_d    = 1'b0;
    done_d      = 1'b0;
    load_en     = 1'b0;
    if (rb_fire) begin
      rb_valid_d = 1'b0;
    end
    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d     = ST_LOAD;
          bits_left_d = BLW'(CHAIN_LEN);
        end
      end
      ST_LOAD: begin
        if (in_valid && in_ready_q) begin
          load_en     = 1'b1;
          bits_left_d = bits_left_q - BLW'(n_ext);
          cfg_en_d    = 1'b1;
          state_d     = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        if (last_bit) begin
          rb_valid_d = 1'b1;
          state_d    = (bits_left_q == '0) ? ST_DRAIN : ST_LOAD;
        end else begin
          cfg_en_d = 1'b1;
        end
      end
      ST_DRAIN: begin
        if (rb_fire) begin
          done_d  = 1'b1;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    busy_d     = (state_d != ST_IDLE);
    // Only one readback word may be outstanding, so input waits for its handshake.
    in_ready_d = (state_d == ST_LOAD) && !rb_valid_d;
  end

  always_ff @(posedge clk or posedge clear_async) begin
    if (clear_async) begin
      state_q     <= ST_IDLE;
      bits_left_q <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      in_ready_q  <= 1'b0;
      rb_valid_q  <= 1'b0;
      cfg_en_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      bits_left_q <= bits_left_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      in_ready_q  <= in_ready_d;
      rb_valid_q  <= rb_valid_d;
      cfg_en_q    <= cfg_en_d;
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign in_ready = in_ready_q;
  assign rb_valid = rb_valid_q;
  assign cfg_en   = cfg_en_q;

endmodule

// File: tb/tb_alm_config_loader.sv
// Self-checking bench for alm_config_loader: a 10-bit tile chain model plus a
// bit-queue reference of the chain contents predicts every readback word.
module tb_alm_config_loader;

  localparam int CL = 10;
  localparam int W  = 4;
  localparam int NW = (CL + W - 1) / W;

  logic         clk = 1'b0;
  logic         clear_async;
  logic         start;
  logic         busy;
  logic         done;
  logic [W-1:0] in_data;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] rb_data;
  logic         rb_valid;
  logic         rb_ready;
  logic         cfg_in;
  logic         cfg_en;
  logic         cfg_out;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  alm_config_loader #(
    .CHAIN_LEN (CL),
    .W         (W)
  ) dut (
    .clk         (clk),
    .clear_async (clear_async),
    .start       (start),
    .busy        (busy),
    .done        (done),
    .in_data     (in_data),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .rb_data     (rb_data),
    .rb_valid    (rb_valid),
    .rb_ready    (rb_ready),
    .cfg_in      (cfg_in),
    .cfg_en      (cfg_en),
    .cfg_out     (cfg_out)
  );

  // Physical tile chain: first bit shifted in is the first to fall out CL shifts later.
  logic [CL-1:0] chain = '0;
  assign cfg_out = chain[CL-1];
  always @(posedge clk) if (cfg_en) chain <= {chain[CL-2:0], cfg_in};

  int           en_count   = 0;
  int           done_count = 0;
  logic [W-1:0] rb_q[$];
  always @(posedge clk) begin
    if (cfg_en) en_count++;
    if (done) done_count++;
    if (rb_valid && rb_ready) rb_q.push_back(rb_data);
  end

  // Reference: chain contents in shift-out order.
  bit model_bits[$];
  bit model_valid = 1'b1;

  task automatic run_load(input logic [NW*W-1:0] words, input int gap, input int stall,
                          input bit start_mid, input string name);
    int en0;
    int d0;
    int t;
    logic [W-1:0] held;
    logic [W-1:0] exp_rb[NW];
    en0 = en_count;
    d0  = done_count;
    rb_q.delete();
    rb_ready = (stall == 0);
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    checks++;
    if (busy !== 1'b1) begin
      errors++; $display("FAIL %s busy_after_start: got %b want 1", name, busy);
    end
    for (int i = 0; i < NW; i++) begin
      t = 0;
      while (in_ready !== 1'b1 && t < 200) begin @(negedge clk); t++; end
      if (t >= 200) begin
        errors++; $display("FAIL %s in_ready_timeout word %0d: got %b want 1", name, i, in_ready);
      end
      if (i > 0) begin
        for (int g = 0; g < gap; g++) begin
          checks++;
          if (cfg_en !== 1'b0) begin
            errors++; $display("FAIL %s gap_cfg_en: got %b want 0", name, cfg_en);
          end
          @(negedge clk);
        end
      end
      in_valid = 1'b1;
      in_data  = words[i*W +: W];
      @(negedge clk);
      in_valid = 1'b0;
      in_data  = W'($urandom);
      if (start_mid && i == 0) begin
        checks++;
        if (cfg_en !== 1'b1) begin
          errors++; $display("FAIL %s shifting_cfg_en: got %b want 1", name, cfg_en);
        end
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
      end
      if (stall > 0 && i == 0) begin
        t = 0;
        while (rb_valid !== 1'b1 && t < 200) begin @(negedge clk); t++; end
        held = rb_data;
        for (int s = 0; s < stall; s++) begin
          @(negedge clk);
          checks++;
          if (rb_valid !== 1'b1 || rb_data !== held || in_ready !== 1'b0 || cfg_en !== 1'b0) begin
            errors++;
            $display("FAIL %s stall: got rb_valid=%b rb_data=%h in_ready=%b cfg_en=%b want 1 %h 0 0",
                     name, rb_valid, rb_data, in_ready, cfg_en, held);
          end
        end
        rb_ready = 1'b1;
      end
    end
    t = 0;
    while (done_count == d0 && t < 300) begin @(negedge clk); t++; end
    repeat (3) @(negedge clk);
    for (int i = 0; i < NW; i++) exp_rb[i] = '0;
    for (int i = 0; i < CL; i++) exp_rb[i / W][i % W] = model_bits[i];
    checks++;
    if (done_count - d0 != 1) begin
      errors++; $display("FAIL %s done_pulses: got %0d want 1", name, done_count - d0);
    end
    checks++;
    if (en_count - en0 != CL) begin
      errors++; $display("FAIL %s cfg_en_cycles: got %0d want %0d", name, en_count - en0, CL);
    end
    checks++;
    if (busy !== 1'b0) begin
      errors++; $display("FAIL %s busy_after_done: got %b want 0", name, busy);
    end
    checks++;
    if (rb_q.size() != NW) begin
      errors++; $display("FAIL %s rb_count: got %0d want %0d", name, rb_q.size(), NW);
    end else if (model_valid) begin
      for (int i = 0; i < NW; i++) begin
        checks++;
        if (rb_q[i] !== exp_rb[i]) begin
          errors++; $display("FAIL %s rb_word%0d: got %h want %h", name, i, rb_q[i], exp_rb[i]);
        end
      end
    end
    model_bits.delete();
    for (int i = 0; i < CL; i++) model_bits.push_back(words[(i / W) * W + (i % W)]);
    model_valid = 1'b1;
    $display("load %s: rb=%p done_pulses=%0d cfg_en_cycles=%0d", name, rb_q,
             done_count - d0, en_count - en0);
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset busy: got %b want 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset done: got %b want 0", done); end
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL reset in_ready: got %b want 0", in_ready); end
    checks++; if (rb_valid !== 1'b0) begin errors++; $display("FAIL reset rb_valid: got %b want 0", rb_valid); end
    checks++; if (rb_data !== '0) begin errors++; $display("FAIL reset rb_data: got %h want 0", rb_data); end
    checks++; if (cfg_in !== 1'b0) begin errors++; $display("FAIL reset cfg_in: got %b want 0", cfg_in); end
    checks++; if (cfg_en !== 1'b0) begin errors++; $display("FAIL reset cfg_en: got %b want 0", cfg_en); end
    clear_async = 1'b0;
    @(negedge clk);
    $display("reset: outputs checked");
  endtask

  task automatic test_abort();
    int en0;
    int t;
    rb_ready = 1'b1;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    en0 = en_count;
    in_valid = 1'b1;
    in_data  = W'($urandom);
    t = 0;
    while (en_count - en0 < 5 && t < 200) begin @(negedge clk); t++; end
    checks++;
    if (cfg_en !== 1'b1) begin
      errors++; $display("FAIL abort sixth_shift_cfg_en: got %b want 1", cfg_en);
    end
    clear_async = 1'b1;
    #1;
    checks++; if (cfg_en !== 1'b0) begin errors++; $display("FAIL abort cfg_en: got %b want 0", cfg_en); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL abort busy: got %b want 0", busy); end
    checks++; if (rb_valid !== 1'b0) begin errors++; $display("FAIL abort rb_valid: got %b want 0", rb_valid); end
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL abort in_ready: got %b want 0", in_ready); end
    in_valid = 1'b0;
    @(negedge clk);
    clear_async = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if (en_count - en0 != 5) begin
      errors++; $display("FAIL abort shift_count: got %0d want 5", en_count - en0);
    end
    $display("abort: cleared after %0d shifts", en_count - en0);
    model_valid = 1'b0;
    run_load(12'hC69, 0, 0, 1'b0, "reload");
    run_load(12'h3E7, 1, 0, 1'b0, "reload_check");
  endtask

  task automatic test_random();
    for (int r = 0; r < 5; r++) begin
      run_load(12'($urandom), int'($urandom_range(0, 3)), int'($urandom_range(0, 4)),
               1'($urandom_range(0, 1)), $sformatf("random%0d", r));
    end
  endtask

  initial begin
    clear_async = 1'b1;
    start       = 1'b0;
    in_valid    = 1'b0;
    in_data     = '0;
    rb_ready    = 1'b1;
    for (int i = 0; i < CL; i++) model_bits.push_back(1'b0);
    test_reset();
    run_load(12'hF5A, 0, 0, 1'b0, "basic");
    run_load(12'h321, 0, 0, 1'b0, "repeat");
    run_load(12'h321, 0, 5, 1'b0, "rb_stall");
    run_load(12'h321, 3, 0, 1'b0, "in_gap");
    run_load(12'hB4C, 0, 0, 1'b1, "start_mid");
    test_abort();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
